// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// State encoding, buffered-entry layout and decoded-field bit positions.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;

    localparam int COND_MSB  = 31;
    localparam int COND_LSB  = 28;
    localparam int OP_MSB    = 27;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 25;
    localparam int FUNCT_LSB = 20;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 12;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_DATA_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake, redirect input and
// decoded instruction output toward the control unit.
interface fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    logic              pc_src;
    logic [ADDR_W-1:0] branch_target;

    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] inst_pc;
    logic [ADDR_W-1:0] pc_plus8;
    logic [3:0]        cond;
    logic [1:0]        op;
    logic [5:0]        funct;
    logic [3:0]        rd;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  pc_src, branch_target,
        output inst_valid,
        input  inst_ready,
        output instr, inst_pc, pc_plus8, cond, op, funct, rd
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output pc_src, branch_target,
        input  inst_valid,
        output inst_ready,
        input  instr, inst_pc, pc_plus8, cond, op, funct, rd
    );

endinterface

// File: rtl/fetch_unit_inst_fifo.sv
// Small power-of-two FIFO holding fetched {instr, pc} entries.
// Clear has priority over push/pop; push when full and pop when empty are dropped.
module inst_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  entry_t                push_data,
    input  logic                  pop,
    output entry_t                head,
    output logic [$clog2(DEPTH):0] count,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, imem request FSM, entry buffer, decode slices.
// Define FETCH_PERF_EN to add the perf_fetched / perf_flushes counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter int              DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushes,
`endif
    fetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FIFO_DEPTH - 1);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_nxt;
    logic [ADDR_W-1:0] disc_addr;
    logic [ADDR_W-1:0] redir_pc;

    logic              redirect;
    logic              ack;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  count;
    entry_t            head;
    entry_t            push_data;

    wire unused_target_bits = ^bus.branch_target[1:0];

    assign redirect  = bus.pc_src;
    assign ack       = bus.imem_ack;
    assign redir_pc  = {bus.branch_target[ADDR_W-1:2], 2'b00};
    assign push      = (state == S_REQ) && ack && !redirect;
    assign pop       = bus.inst_valid && bus.inst_ready;
    assign push_data = '{instr: bus.imem_rdata, pc: fetch_pc};

    inst_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Redirect wins over everything; an unacked request must still be drained.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        if (redirect) begin
            fetch_pc_nxt = redir_pc;
            case (state)
                S_REQ:     state_nxt = ack ? S_IDLE : S_DISCARD;
                S_DISCARD: state_nxt = ack ? S_IDLE : S_DISCARD;
                default:   state_nxt = S_IDLE;
            endcase
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_full)
                        state_nxt = S_REQ;
                end
                S_REQ: begin
                    if (ack) begin
                        fetch_pc_nxt = fetch_pc + ADDR_W'(4);
                        state_nxt    = (pop || count != LAST_SLOT) ? S_REQ : S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (ack)
                        state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC;
            disc_addr <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            if (state == S_REQ && redirect && !ack)
                disc_addr <= fetch_pc;
        end
    end

    // imem_req depends only on registered state, never on inst_ready.
    assign bus.imem_req   = (state != S_IDLE);
    assign bus.imem_addr  = (state == S_DISCARD) ? disc_addr : fetch_pc;

    assign bus.inst_valid = !fifo_empty && !redirect;
    assign bus.instr      = fifo_empty ? '0 : head.instr;
    assign bus.inst_pc    = fifo_empty ? '0 : head.pc;
    assign bus.pc_plus8   = bus.inst_pc + ADDR_W'(8);

    assign bus.cond  = bus.instr[COND_MSB:COND_LSB];
    assign bus.op    = bus.instr[OP_MSB:OP_LSB];
    assign bus.funct = bus.instr[FUNCT_MSB:FUNCT_LSB];
    assign bus.rd    = bus.instr[RD_MSB:RD_LSB];

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushes <= '0;
        end else begin
            if (pop)
                perf_fetched <= perf_fetched + 32'd1;
            if (redirect)
                perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule
